// File: rtl/accu_pkg.sv
// Shared encodings and default sizes for the accumulator sequencer slice.
package accu_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    // Command opcodes as carried on the command port.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/accu_seq_if.sv
// Command and result handshake bundle between a command master and accu_seq.
interface accu_seq_if
    import accu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_data;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_ovf;
    logic             res_zero;

    // Command source and result consumer.
    modport master (
        output cmd_valid, cmd_op, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_ovf, res_zero
    );

    // The accumulator sequencer.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_ovf, res_zero
    );

endinterface

// File: rtl/accu_alu.sv
// Combinational add / two's-complement subtract / pass datapath with flags.
module accu_alu
    import accu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;

    assign sum_add = {1'b0, a} + {1'b0, b};
    // Carry out of this sum is the no-borrow flag.
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Select the result and derive carry / signed overflow for the opcode.
    always_comb begin
        r     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                r     = sum_add[WIDTH-1:0];
                carry = sum_add[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r     = sum_sub[WIDTH-1:0];
                carry = sum_sub[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LOAD: r = b;
            OP_READ: r = a;
            default: r = a;
        endcase
    end

endmodule

// File: rtl/accu_seq.sv
// Accumulator sequencer: buffers commands in a FIFO, executes them one at a
// time against the accumulator, and returns one flagged result per command.
module accu_seq
    import accu_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    accu_seq_if.slave        bus,
    output logic             busy,
    output logic [WIDTH-1:0] acc_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    state_e           state_q, state_d;

    op_e              op_mem_q   [FIFO_DEPTH];
    logic [WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop, exec;

    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_carry_q, res_ovf_q, res_zero_q;

    logic [WIDTH-1:0] alu_r;
    logic             alu_carry, alu_ovf;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    // Acceptance depends only on the registered count, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign push       = bus.cmd_valid && !fifo_full;

    assign bus.cmd_ready = !fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_zero  = res_zero_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign acc_out       = acc_q;

    accu_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a     (acc_q),
        .b     (data_q),
        .op    (op_q),
        .r     (alu_r),
        .carry (alu_carry),
        .ovf   (alu_ovf)
    );

    // Next state: pop in IDLE, execute once, then hold the result until taken.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec    = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]   <= bus.cmd_op;
            data_mem_q[wr_ptr_q] <= bus.cmd_data;
        end
    end

    // Command latch, accumulator update and result beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_ADD;
            data_q      <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            if (pop) begin
                op_q   <= op_mem_q[rd_ptr_q];
                data_q <= data_mem_q[rd_ptr_q];
            end
            if (exec) begin
                acc_q       <= alu_r;
                res_data_q  <= alu_r;
                res_carry_q <= alu_carry;
                res_ovf_q   <= alu_ovf;
                res_zero_q  <= (alu_r == '0);
                res_valid_q <= 1'b1;
            end else if ((state_q == ST_RESP) && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accu_seq.sv
// Directed and short random bench for accu_seq with a command-order result model.
module tb_accu_seq;
    import accu_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       o;
        logic       z;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] acc_out;

    accu_seq_if #(.WIDTH(8)) bus ();

    accu_seq #(
        .WIDTH      (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .acc_out (acc_out)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_res   = 0;
    res_t exp_q[$];
    logic [7:0] m_acc = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input logic [7:0] acc, input op_e op, input logic [7:0] d);
        res_t m;
        int   ua, ud, sa, sd, s;
        ua = int'(acc);
        ud = int'(d);
        sa = (ua > 127) ? ua - 256 : ua;
        sd = (ud > 127) ? ud - 256 : ud;
        m  = '0;
        case (op)
            OP_ADD: begin
                s   = ua + ud;
                m.r = 8'(s);
                m.c = (s > 255);
                s   = sa + sd;
                m.o = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                m.r = 8'(ua - ud);
                m.c = (ua >= ud);
                s   = sa - sd;
                m.o = (s > 127) || (s < -128);
            end
            OP_LOAD: m.r = d;
            default: m.r = acc;
        endcase
        m.z = (m.r == 8'h00);
        return m;
    endfunction

    // Per-cycle checks against the outstanding-command scoreboard.
    always @(negedge clk) begin
        res_t h;
        res_t e;
        if (!rst) begin
            chk("busy_vs_outstanding", 32'(busy), 32'(exp_q.size() != 0));
            if (exp_q.size() < DEPTH) chk("cmd_ready_room", 32'(bus.cmd_ready), 32'd1);
            else if (exp_q.size() > DEPTH) chk("cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 32'(bus.res_valid), 32'd0);
                end else begin
                    h = exp_q[0];
                    chk("res_data", 32'(bus.res_data), 32'(h.r));
                    chk("res_carry", 32'(bus.res_carry), 32'(h.c));
                    chk("res_ovf", 32'(bus.res_ovf), 32'(h.o));
                    chk("res_zero", 32'(bus.res_zero), 32'(h.z));
                    chk("acc_out_in_resp", 32'(acc_out), 32'(h.r));
                    if (bus.res_ready) begin
                        void'(exp_q.pop_front());
                        n_res++;
                    end
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                e = model(m_acc, bus.cmd_op, bus.cmd_data);
                exp_q.push_back(e);
                m_acc = e.r;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_e op, input logic [7:0] d, input bit rand_ready);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && n < 60) begin
            if (rand_ready) bus.res_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("send_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!bus.res_valid && n < 20) begin
            step();
            n++;
        end
        chk("res_valid_wait", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.res_ready = 1'b1;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic do_cmd(input op_e op, input logic [7:0] d, input logic [7:0] er,
                          input logic ec, input logic eo, input logic ez);
        send(op, d, 1'b0);
        wait_result();
        chk("lit_data", 32'(bus.res_data), 32'(er));
        chk("lit_carry", 32'(bus.res_carry), 32'(ec));
        chk("lit_ovf", 32'(bus.res_ovf), 32'(eo));
        chk("lit_zero", 32'(bus.res_zero), 32'(ez));
        chk("lit_acc", 32'(acc_out), 32'(er));
        step();
        chk("res_valid_cleared", 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   base;
        res_t m;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 8'h00;
        bus.res_ready = 1'b0;

        // Model pins: hand-computed results.
        m = model(8'hF0, OP_ADD, 8'h20); chk("model_add_carry", 32'(m), 32'({8'h10, 3'b100}));
        m = model(8'h10, OP_ADD, 8'h70); chk("model_add_ovf",   32'(m), 32'({8'h80, 3'b010}));
        m = model(8'h05, OP_SUB, 8'h05); chk("model_sub_zero",  32'(m), 32'({8'h00, 3'b101}));
        m = model(8'h00, OP_SUB, 8'h01); chk("model_sub_borrow",32'(m), 32'({8'hFF, 3'b000}));
        m = model(8'h80, OP_SUB, 8'h01); chk("model_sub_ovf",   32'(m), 32'({8'h7F, 3'b110}));

        // 1: reset values and first-command latency.
        step();
        step();
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_flags", 32'({bus.res_carry, bus.res_ovf, bus.res_zero}), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acc", 32'(acc_out), 32'd0);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 8'h10;
        step();
        bus.cmd_valid = 1'b0;
        chk("lat_edge_n", 32'(bus.res_valid), 32'd0);
        step();
        chk("lat_edge_n1", 32'(bus.res_valid), 32'd0);
        chk("acc_before_exec", 32'(acc_out), 32'd0);
        step();
        chk("lat_edge_n2", 32'(bus.res_valid), 32'd1);
        chk("load_data", 32'(bus.res_data), 32'h10);
        chk("load_flags", 32'({bus.res_carry, bus.res_ovf, bus.res_zero}), 32'd0);
        chk("load_acc", 32'(acc_out), 32'h10);
        step();
        chk("load_res_cleared", 32'(bus.res_valid), 32'd0);

        // 2: add with carry, add with signed overflow.
        do_cmd(OP_LOAD, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);
        do_cmd(OP_ADD,  8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        do_cmd(OP_ADD,  8'h70, 8'h80, 1'b0, 1'b1, 1'b0);

        // 3: subtract to zero, borrow, read.
        do_cmd(OP_LOAD, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
        do_cmd(OP_SUB,  8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        do_cmd(OP_SUB,  8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        do_cmd(OP_READ, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);

        // 4: consumer stalled, FIFO fills, then drains in order.
        wait_idle();
        base = n_res;
        bus.res_ready = 1'b0;
        send(OP_LOAD, 8'h01, 1'b0);
        send(OP_ADD,  8'h02, 1'b0);
        send(OP_SUB,  8'h03, 1'b0);
        send(OP_ADD,  8'h7F, 1'b0);
        send(OP_SUB,  8'h80, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("full_busy", 32'(busy), 32'd1);
        end
        chk("stall_no_results", 32'(n_res - base), 32'd0);
        bus.res_ready = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 10) begin
            step();
            n++;
        end
        chk("ready_after_first_pop", 32'(n), 32'd2);
        step();
        bus.cmd_valid = 1'b0;
        wait_idle();
        chk("stall_result_count", 32'(n_res - base), 32'd6);

        // 5: push and pop on the same edge with three entries buffered.
        bus.res_ready = 1'b0;
        send(OP_LOAD, 8'h11, 1'b0);
        send(OP_ADD,  8'h22, 1'b0);
        send(OP_ADD,  8'h33, 1'b0);
        send(OP_SUB,  8'h44, 1'b0);
        wait_result();
        bus.res_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 8'h55;
        chk("pushpop_ready_before", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        chk("pushpop_ready_after", 32'(bus.cmd_ready), 32'd1);
        step();
        send(OP_ADD, 8'h66, 1'b0);
        chk("full_after_pushpop", 32'(bus.cmd_ready), 32'd0);
        wait_idle();

        // 5b: random stream with random consumer backpressure.
        for (int i = 0; i < 20; i++) begin
            send(op_e'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);
        end
        wait_idle();
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset while a result is held and two commands are buffered.
        bus.res_ready = 1'b0;
        send(OP_LOAD, 8'h5A, 1'b0);
        send(OP_ADD,  8'h01, 1'b0);
        send(OP_ADD,  8'h02, 1'b0);
        wait_result();
        chk("pre_reset_acc", 32'(acc_out), 32'h5A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        m_acc = 8'h00;
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_acc", 32'(acc_out), 32'd0);
        chk("mid_rst_res_data", 32'(bus.res_data), 32'd0);
        bus.res_ready = 1'b1;
        do_cmd(OP_READ, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1);
        wait_idle();

        chk("all_results_returned", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
